partition_collector_8way: RTL and testbench
===========================================

# partition_collector_8way

Receiving end of the 8-lane hash stage: consumes eight (tuple, tag) lanes with valid/ready handshakes and routes each tuple by the low tag bits into a per-partition line buffer. Whenever a partition accumulates eight tuples, it emits one 512-bit line tagged with its partition id. A flush command drains all partially filled lines. The block sits between the hashing lanes and the partition write-out path of the partitioned hash join.

## Interface
- NUM_PART_BITS, 4, partition index width; NUM_PART = 2**NUM_PART_BITS partitions (legal 1..6)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  [7:0]  per-lane tuple valid
- in_tuple  in  [7:0][63:0]  per-lane tuple
- in_tag  in  [7:0][31:0]  per-lane hash tag; partition = in_tag[i][NUM_PART_BITS-1:0]
- ready_4_input  out  [7:0]  per-lane accept; at most one bit set per cycle
- flush  in  1  single-cycle request to drain partial lines
- flush_done  out  1  one-cycle pulse when the flush completes
- out_valid  out  1  line valid
- out_line  out  [511:0]  slot k = bits [64k+63:64k]
- out_partition  out  [NUM_PART_BITS-1:0]  partition of line
- out_count  out  [3:0]  tuples in line, 1..8
- ready_4_output  in  1  downstream accept

## Operation
- FSM states: ACCEPT (reset state), FLUSH_SCAN, FLUSH_DONE.
- ACCEPT:
  - A round-robin arbiter grants one lane with in_valid set, starting at rr_ptr (reset 0). After a grant, rr_ptr = granted lane + 1 mod 8.
  - A grant is allowed only when the output register is free: !out_valid || ready_4_output.
  - ready_4_input[g] = 1 for the granted lane only. It is combinational from in_valid, rr_ptr and the output state.
- Accepted tuple with partition p is written to slot fill[p], then fill[p] increments (fill is a 4-bit counter per partition, 0..7 stored).
- When the write makes fill[p] reach 8:
  - The whole line, including the new tuple, loads into the output register: out_count=8, out_partition=p.
  - fill[p] clears to 0.
- Output register is single-entry. It holds its value while out_valid && !ready_4_output.
- flush sampled high in ACCEPT:
  - Any tuple granted in that same cycle is still written and is included in the flush.
  - Next state is FLUSH_SCAN with scan_idx=0.
- FLUSH_SCAN:
  - ready_4_input = 0.
  - Each cycle examines partition scan_idx:
    - If fill=0: advance.
    - If fill>0 and the output register is free: load the partial line (out_count=fill, unused slots zero), clear fill, advance.
    - Otherwise: hold.
  - After scan_idx = NUM_PART-1 advances, go to FLUSH_DONE.
- FLUSH_DONE: flush_done=1 for one cycle, then ACCEPT.
- flush asserted outside ACCEPT is ignored.
- Reset (any time, including mid-flush or with the output stalled):
  - All fill counters cleared and buffered tuples discarded.
  - rr_ptr=0, state ACCEPT.
  - Outputs: out_valid=0, out_line=0, out_partition=0, out_count=0, flush_done=0, ready_4_input=0 during reset.

## Timing
- Line completion: tuple accepted at edge t → out_valid=1 after edge t, i.e. visible in cycle t+1.
- Throughput: one tuple per cycle sustained while the downstream keeps ready_4_output=1.
- Back-to-back full lines emit on consecutive cycles.
- A stalled output (out_valid=1, ready_4_output=0) blocks all lanes, including tuples for other partitions.
- Flush duration with no stall: NUM_PART cycles in FLUSH_SCAN plus 1 FLUSH_DONE cycle. Each stall cycle adds one.
- out_valid and its payload remain stable until the handshake completes.
- Unused slots of a partial line are 0. Slots of a full line are in arrival order.

## Configuration
- PART_STATS_EN defined:
  - Adds output stat_accepted out [31:0], the count of accepted tuples. It increments on every grant and wraps 0xFFFFFFFF→0.
  - Adds output stat_lines out [31:0], the count of completed output handshakes, same wrap rule.
  - Both are 0 at reset.
- PART_STATS_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Lane 3 only, 8 tuples with tag=0x5, tuples 0..7, ready_4_output=1 → one line, out_partition=5, out_count=8, slot k = k, out_valid in the cycle after the 8th accept.
- All 8 lanes valid continuously, tags all partition 0 → grants in order 0,1,…,7,0; one line every 8 cycles; ready_4_input one-hot.
- Full line pending with ready_4_output=0 for 5 cycles → ready_4_input=0 for those 5 cycles, out_line stable, no tuple lost.
- 3 tuples to partition 2 and 1 tuple to partition 9, then flush → lines (p=2, count=3, slots 3..7 zero) and (p=9, count=1), then flush_done pulse; fills all 0 afterwards.
- Reset asserted mid-FLUSH_SCAN with out_valid=1 → next cycle out_valid=0, state ACCEPT; a subsequent flush emits nothing and flush_done follows after NUM_PART+1 cycles.
- PART_STATS_EN: stat_accepted preloaded to 0xFFFFFFFE via 2 accepts after force → wraps to 0 on the 2nd accept; stat_lines counts only completed handshakes.

Source files
------------

// File: rtl/partition_collector_8way_if.sv
// rtl/partition_collector_8way_if.sv - lane/flush/line handshake bundle for partition_collector_8way
interface partition_collector_8way_if #(
    parameter int NUM_PART_BITS = 4
);
    logic [7:0]               in_valid;
    logic [7:0][63:0]         in_tuple;
    logic [7:0][31:0]         in_tag;
    logic [7:0]               ready_4_input;
    logic                     flush;
    logic                     flush_done;
    logic                     out_valid;
    logic [511:0]             out_line;
    logic [NUM_PART_BITS-1:0] out_partition;
    logic [3:0]               out_count;
    logic                     ready_4_output;

    // Hashing lanes / write-out consumer side
    modport master (
        output in_valid, in_tuple, in_tag, flush, ready_4_output,
        input  ready_4_input, flush_done, out_valid, out_line, out_partition, out_count
    );

    // Collector side
    modport slave (
        input  in_valid, in_tuple, in_tag, flush, ready_4_output,
        output ready_4_input, flush_done, out_valid, out_line, out_partition, out_count
    );
endinterface

// File: rtl/partition_collector_8way.sv
// rtl/partition_collector_8way.sv - 8-lane tuple collector building 512-bit per-partition lines; PART_STATS_EN adds stat counters
module partition_collector_8way #(
    parameter int NUM_PART_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    partition_collector_8way_if.slave bus
`ifdef PART_STATS_EN
    ,
    output logic [31:0] stat_accepted,
    output logic [31:0] stat_lines
`endif
);
    localparam int NUM_PART = 1 << NUM_PART_BITS;

    typedef enum logic [1:0] {
        ACCEPT,
        FLUSH_SCAN,
        FLUSH_DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [NUM_PART_BITS-1:0] scan_idx;
    logic [NUM_PART_BITS-1:0] scan_idx_next;
    logic [2:0]               rr_ptr;

    logic [3:0]               fill     [NUM_PART];
    logic [7:0][63:0]         line_buf [NUM_PART];

    logic                     out_free;
    logic                     grant_valid;
    logic [2:0]               grant_lane;
    logic [63:0]              grant_tuple;
    logic [NUM_PART_BITS-1:0] grant_part;
    logic                     line_full;
    logic [511:0]             full_line;
    logic [511:0]             partial_line;
    logic                     scan_load;
    logic                     scan_advance;

    // Upper tag bits are only meaningful to the hashing stage
    logic unused_tag_bits;
    assign unused_tag_bits = ^bus.in_tag;

    assign out_free = !bus.out_valid || bus.ready_4_output;

    // Round-robin search from rr_ptr; no grant while the output register is occupied
    always_comb begin
        grant_valid = 1'b0;
        grant_lane  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!grant_valid && bus.in_valid[rr_ptr + 3'(k)]) begin
                grant_valid = 1'b1;
                grant_lane  = rr_ptr + 3'(k);
            end
        end
        grant_valid = grant_valid && (state == ACCEPT) && out_free && !reset;
    end

    assign bus.ready_4_input = grant_valid ? (8'b1 << grant_lane) : 8'b0;
    assign grant_tuple       = bus.in_tuple[grant_lane];
    assign grant_part        = bus.in_tag[grant_lane][NUM_PART_BITS-1:0];
    assign line_full         = grant_valid && (fill[grant_part] == 4'd7);

    // Completed line: the buffered seven tuples plus the one arriving now in slot 7
    always_comb begin
        full_line          = line_buf[grant_part];
        full_line[511:448] = grant_tuple;
    end

    // Partial line for the partition being scanned, slots past the fill level zeroed
    always_comb begin
        partial_line = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < fill[scan_idx]) begin
                partial_line[64*k +: 64] = line_buf[scan_idx][k];
            end
        end
    end

    // Next state: flush walks every partition once, stalling on an occupied output
    always_comb begin
        state_next    = state;
        scan_idx_next = scan_idx;
        scan_load     = 1'b0;
        scan_advance  = 1'b0;
        case (state)
            ACCEPT: begin
                if (bus.flush) begin
                    state_next    = FLUSH_SCAN;
                    scan_idx_next = '0;
                end
            end
            FLUSH_SCAN: begin
                if (fill[scan_idx] == 4'd0) begin
                    scan_advance = 1'b1;
                end else if (out_free) begin
                    scan_load    = 1'b1;
                    scan_advance = 1'b1;
                end
                if (scan_advance) begin
                    if (&scan_idx) begin
                        state_next = FLUSH_DONE;
                    end else begin
                        scan_idx_next = scan_idx + NUM_PART_BITS'(1);
                    end
                end
            end
            FLUSH_DONE: state_next = ACCEPT;
            default:    state_next = ACCEPT;
        endcase
    end

    assign bus.flush_done = (state == FLUSH_DONE) && !reset;

    // State, scan position and arbiter pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCEPT;
            scan_idx <= '0;
            rr_ptr   <= 3'd0;
        end else begin
            state    <= state_next;
            scan_idx <= scan_idx_next;
            if (grant_valid) begin
                rr_ptr <= grant_lane + 3'd1;
            end
        end
    end

    // Per-partition fill levels; clearing them is enough to discard buffered tuples
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PART; p++) begin
                fill[p] <= 4'd0;
            end
        end else begin
            if (grant_valid) begin
                fill[grant_part] <= line_full ? 4'd0 : fill[grant_part] + 4'd1;
            end
            if (scan_load) begin
                fill[scan_idx] <= 4'd0;
            end
        end
    end

    // Line storage; stale slots are masked by the fill level so no reset is needed
    always_ff @(posedge clk) begin
        if (grant_valid) begin
            line_buf[grant_part][fill[grant_part][2:0]] <= grant_tuple;
        end
    end

    // Single-entry output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid     <= 1'b0;
            bus.out_line      <= '0;
            bus.out_partition <= '0;
            bus.out_count     <= 4'd0;
        end else if (line_full) begin
            bus.out_valid     <= 1'b1;
            bus.out_line      <= full_line;
            bus.out_partition <= grant_part;
            bus.out_count     <= 4'd8;
        end else if (scan_load) begin
            bus.out_valid     <= 1'b1;
            bus.out_line      <= partial_line;
            bus.out_partition <= scan_idx;
            bus.out_count     <= fill[scan_idx];
        end else if (bus.ready_4_output) begin
            bus.out_valid     <= 1'b0;
        end
    end

`ifdef PART_STATS_EN
    // Free-running accept and line-handshake counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_accepted <= 32'd0;
            stat_lines    <= 32'd0;
        end else begin
            if (grant_valid) begin
                stat_accepted <= stat_accepted + 32'd1;
            end
            if (bus.out_valid && bus.ready_4_output) begin
                stat_lines <= stat_lines + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_partition_collector_8way.sv
// tb/tb_partition_collector_8way.sv - self-checking bench for partition_collector_8way
module tb_partition_collector_8way;
    localparam int NPB = 4;
    localparam int NP  = 1 << NPB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    partition_collector_8way_if #(.NUM_PART_BITS(NPB)) bus ();

`ifdef PART_STATS_EN
    logic [31:0] stat_accepted;
    logic [31:0] stat_lines;
`endif

    partition_collector_8way #(.NUM_PART_BITS(NPB)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef PART_STATS_EN
        ,
        .stat_accepted(stat_accepted),
        .stat_lines(stat_lines)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model and scoreboard, stepped once per cycle on the falling edge
    typedef struct {
        logic [NPB-1:0] part;
        logic [3:0]     count;
        logic [511:0]   line;
    } line_t;

    line_t       exp_q[$];
    int          m_state;
    int          m_rr;
    int          m_scan;
    int          m_fill [NP];
    logic [63:0] m_buf  [NP][8];
    bit          m_ov;

    function automatic logic [511:0] model_line(input int p, input int n);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < n; k++) l[64*k +: 64] = m_buf[p][k];
        return l;
    endfunction

    always @(negedge clk) begin : model
        logic [7:0] exp_rdy;
        bit         free;
        bit         nov;
        bit         adv_scan;
        int         g;
        int         p;
        line_t      e;
        if (reset) begin
            check("reset_ready_4_input", bus.ready_4_input, 8'h00);
            check("reset_flush_done", bus.flush_done, 1'b0);
            m_state = 0; m_rr = 0; m_scan = 0; m_ov = 0;
            for (int i = 0; i < NP; i++) m_fill[i] = 0;
            exp_q.delete();
        end else begin
            free    = !m_ov || bus.ready_4_output;
            exp_rdy = 8'h00;
            g       = -1;
            if (m_state == 0 && free) begin
                for (int k = 0; k < 8; k++) begin
                    if (g < 0 && bus.in_valid[(m_rr + k) % 8]) g = (m_rr + k) % 8;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("ready_4_input", bus.ready_4_input, exp_rdy);
            check("flush_done", bus.flush_done, m_state == 2);
            check("out_valid", bus.out_valid, m_ov);
            nov = m_ov && !bus.ready_4_output;
            if (m_ov && bus.ready_4_output) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_line: got partition %0d count %0d, expected no line",
                             bus.out_partition, bus.out_count);
                end else begin
                    e = exp_q.pop_front();
                    check("out_partition", bus.out_partition, e.part);
                    check("out_count", bus.out_count, e.count);
                    check("out_line", bus.out_line, e.line);
                end
            end
            if (g >= 0) begin
                p = int'(bus.in_tag[g][NPB-1:0]);
                m_buf[p][m_fill[p]] = bus.in_tuple[g];
                m_fill[p]++;
                m_rr = (g + 1) % 8;
                if (m_fill[p] == 8) begin
                    e.part = NPB'(p); e.count = 4'd8; e.line = model_line(p, 8);
                    exp_q.push_back(e);
                    nov = 1'b1;
                    m_fill[p] = 0;
                end
            end
            case (m_state)
                0: if (bus.flush) begin m_state = 1; m_scan = 0; end
                1: begin
                    adv_scan = 1'b0;
                    if (m_fill[m_scan] == 0) begin
                        adv_scan = 1'b1;
                    end else if (free) begin
                        e.part = NPB'(m_scan); e.count = 4'(m_fill[m_scan]);
                        e.line = model_line(m_scan, m_fill[m_scan]);
                        exp_q.push_back(e);
                        nov = 1'b1;
                        m_fill[m_scan] = 0;
                        adv_scan = 1'b1;
                    end
                    if (adv_scan) begin
                        if (m_scan == NP - 1) m_state = 2;
                        else m_scan++;
                    end
                end
                default: m_state = 0;
            endcase
            m_ov = nov;
        end
    end

    // Called at a falling edge: moves to just after the next rising edge, refreshing consumed lanes
    task automatic adv();
        logic [7:0] acc;
        acc = bus.ready_4_input & bus.in_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) if (acc[i]) bus.in_tuple[i] = {$urandom, $urandom};
    endtask

    // Pulses flush and returns the number of cycles until flush_done is seen
    task automatic run_flush(output int n);
        bus.flush = 1'b1;
        @(negedge clk);
        adv();
        bus.flush = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.flush_done) break;
            adv();
        end
        adv();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        adv();
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] valid;
        logic [7:0] exp_rdy;
    } vec_t;

    vec_t        tbl [16];
    int          n;
    logic [511:0] held;

    initial begin
        tbl[0]  = '{8'hFF, 8'h01}; tbl[1]  = '{8'hFF, 8'h02}; tbl[2]  = '{8'hFF, 8'h04};
        tbl[3]  = '{8'hFF, 8'h08}; tbl[4]  = '{8'hFF, 8'h10}; tbl[5]  = '{8'hFF, 8'h20};
        tbl[6]  = '{8'hFF, 8'h40}; tbl[7]  = '{8'hFF, 8'h80}; tbl[8]  = '{8'hFF, 8'h01};
        tbl[9]  = '{8'h00, 8'h00}; tbl[10] = '{8'h01, 8'h01}; tbl[11] = '{8'h84, 8'h04};
        tbl[12] = '{8'h84, 8'h80}; tbl[13] = '{8'h84, 8'h04}; tbl[14] = '{8'h09, 8'h08};
        tbl[15] = '{8'h09, 8'h01};

        reset              = 1'b1;
        bus.in_valid       = 8'hFF;
        bus.flush          = 1'b0;
        bus.ready_4_output = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_tuple[i] = {$urandom, $urandom};
            bus.in_tag[i]   = $urandom & 32'hFFFF_FFF0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_line", bus.out_line, 512'd0);
        check("rst_out_partition", bus.out_partition, 4'd0);
        check("rst_out_count", bus.out_count, 4'd0);
        check("rst_ready", bus.ready_4_input, 8'h00);
        adv();
        reset = 1'b0;

        // Round-robin table, all tuples to partition 0 (upper tag bits random)
        for (int r = 0; r < 16; r++) begin
            bus.in_valid = tbl[r].valid;
            @(negedge clk);
            check($sformatf("rr_row%0d", r), bus.ready_4_input, tbl[r].exp_rdy);
            adv();
        end
        bus.in_valid = 8'h00;
        run_flush(n);
        check("flush_p0_cycles", n, NP + 1);

        // Lane 3 only, tag 5, tuples 0..7
        for (int i = 0; i < 8; i++) bus.in_tag[i] = 32'h5;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid    = 8'h08;
            bus.in_tuple[3] = 64'(k);
            @(negedge clk);
            check("lane3_grant", bus.ready_4_input, 8'h08);
            check("lane3_not_yet", bus.out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 8'h00;
        @(negedge clk);
        check("lane3_out_valid", bus.out_valid, 1'b1);
        check("lane3_partition", bus.out_partition, 4'd5);
        check("lane3_count", bus.out_count, 4'd8);
        for (int k = 0; k < 8; k++) check($sformatf("lane3_slot%0d", k), bus.out_line[64*k +: 64], 64'(k));
        adv();

        // Output stall with every lane requesting partition 1
        for (int i = 0; i < 8; i++) bus.in_tag[i] = 32'h1;
        bus.in_valid       = 8'hFF;
        bus.ready_4_output = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 20) begin
            adv();
            @(negedge clk);
            n++;
        end
        check("stall_fill_cycles", n, 8);
        held = bus.out_line;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            check("stall_ready", bus.ready_4_input, 8'h00);
            check("stall_line", bus.out_line, held);
            adv();
        end
        bus.ready_4_output = 1'b1;
        repeat (4) begin @(negedge clk); adv(); end
        bus.in_valid = 8'h00;
        @(negedge clk);
        adv();

        // Partial lines: 3 tuples to partition 2, 1 to partition 9
        do_reset();
        bus.in_tag[0] = 32'h2;
        bus.in_tag[5] = 32'h9;
        bus.in_valid  = 8'h01;
        repeat (3) begin @(negedge clk); check("p2_grant", bus.ready_4_input, 8'h01); adv(); end
        bus.in_valid = 8'h20;
        @(negedge clk);
        check("p9_grant", bus.ready_4_input, 8'h20);
        adv();
        bus.in_valid = 8'h00;
        run_flush(n);
        check("flush_partial_cycles", n, NP + 1);
        check("flush_partial_drained", exp_q.size(), 0);
        run_flush(n);
        check("flush_empty_cycles", n, NP + 1);

        // Reset in the middle of a stalled flush
        bus.in_tag[1] = 32'h0;
        bus.in_tag[4] = 32'h4;
        bus.in_valid  = 8'h02;
        repeat (2) begin @(negedge clk); adv(); end
        bus.in_valid = 8'h10;
        @(negedge clk);
        adv();
        bus.in_valid       = 8'h00;
        bus.ready_4_output = 1'b0;
        bus.flush          = 1'b1;
        @(negedge clk);
        adv();
        bus.flush = 1'b0;
        @(negedge clk); adv();
        @(negedge clk);
        check("midflush_out_valid", bus.out_valid, 1'b1);
        adv();
        @(negedge clk); adv();
        @(negedge clk); adv();
        reset = 1'b1;
        @(negedge clk);
        adv();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_out_valid", bus.out_valid, 1'b0);
        check("post_reset_out_line", bus.out_line, 512'd0);
        check("post_reset_out_count", bus.out_count, 4'd0);
        adv();
        bus.ready_4_output = 1'b1;
        run_flush(n);
        check("post_reset_flush_cycles", n, NP + 1);

`ifdef PART_STATS_EN
        do_reset();
        @(negedge clk);
        check("stat_accepted_reset", stat_accepted, 32'd0);
        check("stat_lines_reset", stat_lines, 32'd0);
        adv();
        force dut.stat_accepted = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stat_accepted;
        adv();
        bus.in_tag[0] = 32'h6;
        bus.in_valid  = 8'h01;
        @(negedge clk); adv();
        @(negedge clk);
        check("stat_accepted_max", stat_accepted, 32'hFFFF_FFFF);
        adv();
        bus.in_valid = 8'h00;
        @(negedge clk);
        check("stat_accepted_wrap", stat_accepted, 32'd0);
        adv();
        bus.ready_4_output = 1'b0;
        bus.in_valid       = 8'h01;
        repeat (6) begin @(negedge clk); adv(); end
        bus.in_valid = 8'h00;
        @(negedge clk);
        check("stat_lines_stalled0", stat_lines, 32'd0);
        adv();
        @(negedge clk);
        check("stat_lines_stalled1", stat_lines, 32'd0);
        adv();
        bus.ready_4_output = 1'b1;
        @(negedge clk); adv();
        @(negedge clk);
        check("stat_lines_done", stat_lines, 32'd1);
        adv();
`endif

        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
